apb_requester: RTL and testbench

//  Parametrised APB4 requester (manager): converts a valid/ready command stream into APB4 transfers

---
 rtl/apb_requester.sv | 207 ++++++++++++++++++++
 tb/tb_apb_requester.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_requester.sv
// apb_requester
//   APB4 requester. Takes one command at a time from a valid/ready stream,
//   runs a single APB4 SETUP/ACCESS transfer to the selected completer, and
//   returns read data plus error status on a valid/ready response stream.
//
//   Optional feature macro: APB_REQ_TIMEOUT_EN
//     defined   - an ACCESS phase that sees TIMEOUT_CYCLES wait cycles is
//                 abandoned and answered with rsp_err=1, rsp_rdata=0.
//     undefined - ACCESS waits for pready indefinitely; TIMEOUT_CYCLES unused.
//
// Ports
//   pclk, presetn           clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready     command handshake
//   cmd_write/addr/wdata/strb/prot/sel   command fields
//   rsp_valid/rsp_ready     response handshake
//   rsp_rdata, rsp_err      response payload (rdata 0 for writes)
//   psel, penable, pwrite, paddr, pwdata, pstrb, pprot   APB request
//   prdata, pready, pslverr APB completion
//
// State   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | ready for a command
// S_SETUP | APB setup phase, psel high, penable low
// S_ACCESS| APB access phase, waiting for pready
// S_RESP  | response presented, waiting for rsp_ready

module apb_requester #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SEL        = 1,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int STRB_WIDTH    = DATA_WIDTH / 8,
    localparam int SEL_WIDTH     = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_strb,
    input  logic [2:0]            cmd_prot,
    input  logic [SEL_WIDTH-1:0]  cmd_sel,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [NUM_SEL-1:0]    psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    output logic [STRB_WIDTH-1:0] pstrb,
    output logic [2:0]            pprot,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    if (DATA_WIDTH != 8 && DATA_WIDTH != 16 && DATA_WIDTH != 32) begin : g_bad_width
        $error("apb_requester: DATA_WIDTH must be 8, 16 or 32");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb_requester: TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic                  r_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_WIDTH-1:0] r_strb;
    logic [2:0]            r_prot;
    logic [SEL_WIDTH-1:0]  r_sel;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;

    logic                  w_accept;
    logic                  w_sel_ok;
    logic                  w_complete;
    logic                  w_timeout;
    logic [NUM_SEL-1:0]    w_psel_dec;

    assign w_accept   = cmd_valid && (r_state == S_IDLE);
    assign w_sel_ok   = 32'(cmd_sel) < 32'(NUM_SEL);
    assign w_complete = (r_state == S_ACCESS) && pready;
    assign w_psel_dec = NUM_SEL'(1) << r_sel;

`ifdef APB_REQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_wait_cnt;

    // Firing on the last pready=0 cycle means the limit is hit exactly after
    // TIMEOUT_CYCLES wait cycles; pready=1 on that cycle completes normally.
    assign w_timeout = (r_state == S_ACCESS) && !pready && (r_wait_cnt == TO_LAST);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_SETUP) begin
            r_wait_cnt <= '0;
        end else if ((r_state == S_ACCESS) && !pready) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        psel      = '0;
        penable   = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (w_accept) begin
                    w_next = w_sel_ok ? S_SETUP : S_RESP;
                end
            end
            S_SETUP: begin
                psel   = w_psel_dec;
                w_next = S_ACCESS;
            end
            S_ACCESS: begin
                psel    = w_psel_dec;
                penable = 1'b1;
                if (pready || w_timeout) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // APB request fields are only loaded for a decodable command so a decode
    // error leaves the bus completely quiet. Read data/strobes are forced to 0.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_strb  <= '0;
            r_prot  <= '0;
            r_sel   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_sel_ok) begin
                    r_write <= cmd_write;
                    r_addr  <= cmd_addr;
                    r_wdata <= cmd_write ? cmd_wdata : '0;
                    r_strb  <= cmd_write ? cmd_strb : '0;
                    r_prot  <= cmd_prot;
                    r_sel   <= cmd_sel;
                end else begin
                    r_rdata <= '0;
                    r_err   <= 1'b1;
                end
            end
            if (w_complete) begin
                r_rdata <= r_write ? '0 : prdata;
                r_err   <= pslverr;
            end else if (w_timeout) begin
                r_rdata <= '0;
                r_err   <= 1'b1;
            end
        end
    end

    assign pwrite    = r_write;
    assign paddr     = r_addr;
    assign pwdata    = r_wdata;
    assign pstrb     = r_strb;
    assign pprot     = r_prot;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_apb_requester.sv
module tb_apb_requester;

    localparam int NSEL = 3;
    localparam int TB_TIMEOUT = 8;
`ifdef APB_REQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        pclk = 1'b0;
    logic        presetn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_strb;
    logic [2:0]  cmd_prot;
    logic [1:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [2:0]  psel;
    logic        penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic        pready, pslverr;

    apb_requester #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SEL(NSEL), .TIMEOUT_CYCLES(TB_TIMEOUT)
    ) dut (
        .pclk(pclk), .presetn(presetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .cmd_prot(cmd_prot), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        logic [1:0]  sel;
        int          waits;
        logic        stuck;
        logic [31:0] prdata;
        logic        slverr;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;
    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Scoreboard: a response is consumed on the edge following a negedge
    // where rsp_valid and rsp_ready are both high.
    always @(negedge pclk) begin
        if (presetn && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 64'(rsp_valid), 64'(0));
            end else begin
                rsp_t e;
                e = sb.pop_front();
                chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                chk("rsp_err", 64'(rsp_err), 64'(e.err));
            end
        end
    end

    // Caller is between posedge+1 and negedge of an IDLE cycle. Returns at the
    // first RESP negedge, with the response check done by the scoreboard.
    task automatic issue_and_access(input vec_t v);
        logic [2:0]  e_psel;
        logic [31:0] e_wdata;
        logic [3:0]  e_strb;
        int          n_acc;
        e_psel  = 3'(1) << v.sel;
        e_wdata = v.write ? v.wdata : 32'h0;
        e_strb  = v.write ? v.strb : 4'h0;
        n_acc   = (v.stuck && TO_EN) ? TB_TIMEOUT : v.waits + 1;
        cmd_valid = 1'b1;
        cmd_write = v.write; cmd_addr = v.addr; cmd_wdata = v.wdata;
        cmd_strb  = v.strb;  cmd_prot = v.prot; cmd_sel   = v.sel;
        @(negedge pclk);
        chk("idle_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("idle_psel", 64'(psel), 64'(0));
        sb.push_back('{rdata: v.exp_rdata, err: v.exp_err});
        @(posedge pclk); #1;
        cmd_valid = 1'b0;
        cmd_write = ~v.write; cmd_addr = ~v.addr; cmd_wdata = ~v.wdata;
        cmd_strb  = ~v.strb;  cmd_prot = ~v.prot;
        pready = 1'b1; pslverr = 1'b1; prdata = $urandom;
        if (32'(v.sel) >= NSEL) begin
            @(negedge pclk);
            pready = 1'b0;
            chk("dec_psel", 64'(psel), 64'(0));
            chk("dec_penable", 64'(penable), 64'(0));
            chk("dec_rsp_valid", 64'(rsp_valid), 64'(1));
            chk("dec_cmd_ready", 64'(cmd_ready), 64'(0));
            return;
        end
        @(negedge pclk);
        chk("setup_psel", 64'(psel), 64'(e_psel));
        chk("setup_penable", 64'(penable), 64'(0));
        chk("setup_cmd_ready", 64'(cmd_ready), 64'(0));
        chk("setup_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("setup_paddr", 64'(paddr), 64'(v.addr));
        chk("setup_pwrite", 64'(pwrite), 64'(v.write));
        chk("setup_pwdata", 64'(pwdata), 64'(e_wdata));
        chk("setup_pstrb", 64'(pstrb), 64'(e_strb));
        chk("setup_pprot", 64'(pprot), 64'(v.prot));
        for (int i = 0; i < n_acc; i++) begin
            @(negedge pclk);
            chk("acc_psel", 64'(psel), 64'(e_psel));
            chk("acc_penable", 64'(penable), 64'(1));
            chk("acc_paddr", 64'(paddr), 64'(v.addr));
            chk("acc_pwdata", 64'(pwdata), 64'(e_wdata));
            chk("acc_pstrb", 64'(pstrb), 64'(e_strb));
            chk("acc_rsp_valid", 64'(rsp_valid), 64'(0));
            if (!(v.stuck && TO_EN) && i == v.waits) begin
                pready = 1'b1; prdata = v.prdata; pslverr = v.slverr;
            end else begin
                pready = 1'b0; prdata = $urandom; pslverr = 1'b1;
            end
        end
        @(negedge pclk);
        pready = 1'b0;
        chk("resp_psel", 64'(psel), 64'(0));
        chk("resp_penable", 64'(penable), 64'(0));
        chk("resp_rsp_valid", 64'(rsp_valid), 64'(1));
        chk("resp_cmd_ready", 64'(cmd_ready), 64'(0));
        chk("resp_paddr", 64'(paddr), 64'(v.addr));
        chk("resp_pprot", 64'(pprot), 64'(v.prot));
    endtask

    task automatic run_vec(input vec_t v);
        rsp_ready = 1'b1;
        issue_and_access(v);
        @(posedge pclk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vecs[0] = '{1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 3'd0, 2'd0, 0,   1'b0, 32'hAAAA5555, 1'b0, 32'h0,        1'b0};
        vecs[1] = '{1'b0, 32'h20,       32'hFFFFFFFF, 4'hF, 3'd2, 2'd1, 3,   1'b0, 32'h12345678, 1'b1, 32'h12345678, 1'b1};
        vecs[2] = '{1'b0, 32'hFFFFFFFC, 32'h0,        4'h0, 3'd1, 2'd2, 1,   1'b0, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 1'b0};
        vecs[3] = '{1'b1, 32'h104,      32'h0F0F0F0F, 4'h0, 3'd4, 2'd1, 2,   1'b0, 32'h77777777, 1'b1, 32'h0,        1'b1};
        vecs[4] = '{1'b1, 32'h200,      32'h11223344, 4'h5, 3'd7, 2'd2, 0,   1'b0, 32'h11111111, 1'b0, 32'h0,        1'b0};
        vecs[5] = '{1'b0, 32'h300,      32'h0,        4'h0, 3'd0, 2'd2, 7,   1'b0, 32'h89ABCDEF, 1'b0, 32'h89ABCDEF, 1'b0};
        vecs[6] = '{1'b0, 32'h400,      32'h0,        4'h0, 3'd0, 2'd3, 0,   1'b0, 32'h0,        1'b0, 32'h0,        1'b1};
        vecs[7] = '{1'b1, 32'h404,      32'h55AA55AA, 4'hF, 3'd0, 2'd3, 0,   1'b0, 32'h0,        1'b0, 32'h0,        1'b1};
        vecs[8] = '{1'b0, 32'h8,        32'h0,        4'h0, 3'd0, 2'd0, 0,   1'b0, 32'h0BADC0DE, 1'b0, 32'h0BADC0DE, 1'b0};
        vecs[9] = '{1'b0, 32'h40,       32'h0,        4'h0, 3'd0, 2'd0, 100, 1'b1, 32'h5A5A5A5A, 1'b0,
                    TO_EN ? 32'h0 : 32'h5A5A5A5A, TO_EN};

        presetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_strb = '0; cmd_prot = '0; cmd_sel = '0; rsp_ready = 1'b1;
        prdata = '0; pready = 1'b0; pslverr = 1'b0;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        presetn = 1'b1;
        @(posedge pclk); #1;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_psel", 64'(psel), 64'(0));
        chk("rst_penable", 64'(penable), 64'(0));
        chk("rst_paddr", 64'(paddr), 64'(0));
        chk("rst_pwrite", 64'(pwrite), 64'(0));
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        chk("rst_rsp_err", 64'(rsp_err), 64'(0));

        for (int k = 0; k < 10; k++) run_vec(vecs[k]);

        // Response backpressure with a second command already waiting.
        v = '{1'b0, 32'h50, 32'h0, 4'h0, 3'd3, 2'd1, 1, 1'b0, 32'hFEEDFACE, 1'b0, 32'hFEEDFACE, 1'b0};
        rsp_ready = 1'b0;
        issue_and_access(v);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h60; cmd_wdata = 32'h01020304;
        cmd_strb = 4'h3; cmd_prot = 3'd0; cmd_sel = 2'd2;
        for (int c = 0; c < 5; c++) begin
            @(negedge pclk);
            chk("bp_rsp_valid", 64'(rsp_valid), 64'(1));
            chk("bp_rsp_rdata", 64'(rsp_rdata), 64'(32'hFEEDFACE));
            chk("bp_rsp_err", 64'(rsp_err), 64'(0));
            chk("bp_cmd_ready", 64'(cmd_ready), 64'(0));
            chk("bp_psel", 64'(psel), 64'(0));
        end
        @(posedge pclk); #1;
        rsp_ready = 1'b1;
        @(posedge pclk); #1;
        v = '{1'b1, 32'h60, 32'h01020304, 4'h3, 3'd0, 2'd2, 0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
        issue_and_access(v);
        @(posedge pclk); #1;

        // Reset asserted mid-ACCESS, away from any clock edge.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h70; cmd_sel = 2'd1; pready = 1'b0;
        @(posedge pclk); #1;
        cmd_valid = 1'b0;
        @(posedge pclk); #1;
        @(posedge pclk); #2;
        chk("pre_rst_penable", 64'(penable), 64'(1));
        presetn = 1'b0;
        #1;
        chk("async_rst_psel", 64'(psel), 64'(0));
        chk("async_rst_penable", 64'(penable), 64'(0));
        chk("async_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("async_rst_cmd_ready", 64'(cmd_ready), 64'(1));
        @(negedge pclk);
        presetn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge pclk);
            chk("post_rst_rsp_valid", 64'(rsp_valid), 64'(0));
            chk("post_rst_cmd_ready", 64'(cmd_ready), 64'(1));
        end
        @(posedge pclk); #1;
        run_vec(vecs[1]);

        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
